// File: rtl/ser_video_out_if.sv
`default_nettype none
// ============================================================================
//  Module      : ser_video_out_if
//  Description : Pixel-side and serial-side signal bundle for ser_video_out.
//                The master side (the video source plus the downstream
//                shift-register/DAC chips) drives the parallel pixel and the
//                CLK_6MB pixel strobe. The slave side (the serialiser) drives
//                the serial data, bit clock, latch strobe and overrun flag.
//  Signals     :
//    CLK_6MB                    pixel clock, sampled as data
//    VIDEO_R/G/B      [BITS]    parallel pixel, stable around CLK_6MB rise
//    VIDEO_R/G/B_SER            serial data, MSB first
//    VIDEO_CLK_SER              serial bit clock (receivers sample on rise)
//    VIDEO_LAT_SER              one-cycle latch strobe after the last bit
//    OVERRUN                    sticky pending-pixel overwrite flag
//  Revision    : 1.0 - initial release
// ============================================================================
interface ser_video_out_if #(
    parameter int BITS = 7
);
    logic            CLK_6MB;
    logic [BITS-1:0] VIDEO_R;
    logic [BITS-1:0] VIDEO_G;
    logic [BITS-1:0] VIDEO_B;
    logic            VIDEO_R_SER;
    logic            VIDEO_G_SER;
    logic            VIDEO_B_SER;
    logic            VIDEO_CLK_SER;
    logic            VIDEO_LAT_SER;
    logic            OVERRUN;

    modport master (
        output CLK_6MB,
        output VIDEO_R,
        output VIDEO_G,
        output VIDEO_B,
        input  VIDEO_R_SER,
        input  VIDEO_G_SER,
        input  VIDEO_B_SER,
        input  VIDEO_CLK_SER,
        input  VIDEO_LAT_SER,
        input  OVERRUN
    );

    modport slave (
        input  CLK_6MB,
        input  VIDEO_R,
        input  VIDEO_G,
        input  VIDEO_B,
        output VIDEO_R_SER,
        output VIDEO_G_SER,
        output VIDEO_B_SER,
        output VIDEO_CLK_SER,
        output VIDEO_LAT_SER,
        output OVERRUN
    );
endinterface
`default_nettype wire

// File: rtl/ser_video_out.sv
`default_nettype none
// ============================================================================
//  Module      : ser_video_out
//  Description : Serial video output stage. Samples the parallel R/G/B pixel
//                on every CLK_6MB rising edge (CLK_6MB is treated as data and
//                synchronised into CLK_SERVID) and shifts each channel out
//                MSB first with a shared bit clock and a latch strobe. One
//                pending pixel is double-buffered so a 16:1 clock ratio
//                streams back-to-back with no idle cycles.
//  Ports       :
//    CLK_SERVID  in   serial clock, sole clock of the block
//    RESET       in   synchronous, active-high reset
//    vid         if   ser_video_out_if.slave (pixel in, serial out, OVERRUN)
//  Parameters  :
//    BITS         bits per colour channel (>= 2)
//    SYNC_STAGES  synchroniser flops on CLK_6MB (>= 2)
//  Revision    : 1.0 - initial release
// ============================================================================
module ser_video_out #(
    parameter int BITS        = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK_SERVID,
    input  logic                  RESET,
    ser_video_out_if.slave        vid
);

    localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int PIX_W = 3 * BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // CLK_6MB synchroniser and rising-edge detector
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync;
    logic                   delayed;
    logic                   pix_edge;

    always_ff @(posedge CLK_SERVID) begin
        if (RESET) begin
            sync    <= '0;
            delayed <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], vid.CLK_6MB};
            delayed <= sync[SYNC_STAGES-1];
        end
    end

    assign pix_edge = sync[SYNC_STAGES-1] & ~delayed;

    // ------------------------------------------------------------------
    // Pending buffer, shift register and shifter FSM
    // ------------------------------------------------------------------
    state_t             state;
    logic [PIX_W-1:0]   pend;
    logic               pend_valid;
    logic [PIX_W-1:0]   sr;
    logic [CNT_W-1:0]   bit_cnt;
    logic               phase;
    logic               clk_ser;
    logic               lat_ser;
    logic               overrun;
    logic [PIX_W-1:0]   sr_shifted;

    // Each channel shifts left on its own; a zero enters at each channel LSB
    // so no bit leaks from one colour into the next.
    assign sr_shifted = {sr[3*BITS-2 -: BITS-1], 1'b0,
                         sr[2*BITS-2 -: BITS-1], 1'b0,
                         sr[BITS-2   -: BITS-1], 1'b0};

    always_ff @(posedge CLK_SERVID) begin
        if (RESET) begin
            state      <= ST_IDLE;
            pend       <= '0;
            pend_valid <= 1'b0;
            sr         <= '0;
            bit_cnt    <= '0;
            phase      <= 1'b0;
            clk_ser    <= 1'b0;
            lat_ser    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            lat_ser <= 1'b0;

            // A fresh capture always wins over the LOAD consuming the slot,
            // so a pixel arriving in the LOAD cycle stays pending. It is only
            // an overrun when the slot is full and nobody is taking it.
            if (pix_edge) begin
                pend       <= {vid.VIDEO_R, vid.VIDEO_G, vid.VIDEO_B};
                pend_valid <= 1'b1;
                if (pend_valid && (state != ST_LOAD)) begin
                    overrun <= 1'b1;
                end
            end else if (state == ST_LOAD) begin
                pend_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    clk_ser <= 1'b0;
                    if (pend_valid) begin
                        state <= ST_LOAD;
                    end
                end

                // The SR MSBs drive the serial lines directly, so loading SR
                // here puts bit 0 on the wires in the first SHIFT cycle.
                ST_LOAD: begin
                    sr      <= pend;
                    bit_cnt <= '0;
                    phase   <= 1'b0;
                    clk_ser <= 1'b0;
                    state   <= ST_SHIFT;
                end

                ST_SHIFT: begin
                    if (!phase) begin
                        clk_ser <= 1'b1;
                        phase   <= 1'b1;
                    end else begin
                        clk_ser <= 1'b0;
                        phase   <= 1'b0;
                        if (bit_cnt == CNT_W'(BITS - 1)) begin
                            // Last bit stays on the wires through LATCH.
                            lat_ser <= 1'b1;
                            state   <= ST_LATCH;
                        end else begin
                            sr      <= sr_shifted;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                // Serial lines return to rest after the latch; the next LOAD
                // (if any) reloads SR one cycle later.
                ST_LATCH: begin
                    clk_ser <= 1'b0;
                    sr      <= '0;
                    state   <= pend_valid ? ST_LOAD : ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: every one comes straight from a flop
    // ------------------------------------------------------------------
    assign vid.VIDEO_R_SER   = sr[3*BITS-1];
    assign vid.VIDEO_G_SER   = sr[2*BITS-1];
    assign vid.VIDEO_B_SER   = sr[BITS-1];
    assign vid.VIDEO_CLK_SER = clk_ser;
    assign vid.VIDEO_LAT_SER = lat_ser;
    assign vid.OVERRUN       = overrun;

endmodule
`default_nettype wire

// File: tb/tb_ser_video_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ser_video_out
//  Description : Self-checking bench for ser_video_out. A pixel-level model
//                (queue of presented pixels, bit reassembly on each serial
//                clock rise) is compared against the DUT on every cycle,
//                plus hand-computed latency and data literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ser_video_out;

    localparam int BITS  = 7;
    localparam int PIX_W = 3 * BITS;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic rst_seen  = 1'b0;
    int   cyc       = 0;
    int   checks    = 0;
    int   failures  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        rst_seen <= rst;
    end

    ser_video_out_if #(.BITS(BITS)) vif ();

    ser_video_out #(
        .BITS        (BITS),
        .SYNC_STAGES (2)
    ) dut (
        .CLK_SERVID (clk),
        .RESET      (rst),
        .vid        (vif.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Model state
    // ------------------------------------------------------------------
    bit              idle_check = 1'b0;
    bit              loose      = 1'b0;
    logic [PIX_W-1:0] exp_q[$];
    logic [PIX_W-1:0] presented[$];
    int              last_idx   = -1;
    int              lat_cyc[$];
    logic [PIX_W-1:0] last_pix  = '0;
    int              first_r_cyc   = -1;
    int              first_clk_cyc = -1;
    int              first_ovr_cyc = -1;
    int              nbits = 0;
    logic [BITS-1:0] acc_r = '0, acc_g = '0, acc_b = '0;
    logic            prev_clk_ser = 1'b0;
    logic            prev_ovr     = 1'b0;
    logic [2:0]      prev_data    = '0;

    // ------------------------------------------------------------------
    // Compare process: sampled on the falling edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin : mon
        logic [2:0]       d;
        logic [PIX_W-1:0] pix;
        bit               found;
        d = {vif.VIDEO_R_SER, vif.VIDEO_G_SER, vif.VIDEO_B_SER};
        if (rst_seen) begin
            chk("reset_outputs", {26'd0, d, vif.VIDEO_CLK_SER, vif.VIDEO_LAT_SER, vif.OVERRUN}, 32'd0);
            nbits        = 0;
            acc_r        = '0;
            acc_g        = '0;
            acc_b        = '0;
            prev_clk_ser = 1'b0;
            prev_ovr     = 1'b0;
            prev_data    = '0;
        end else begin
            if (idle_check)
                chk("idle_outputs", {26'd0, d, vif.VIDEO_CLK_SER, vif.VIDEO_LAT_SER, vif.OVERRUN}, 32'd0);
            if (vif.VIDEO_R_SER && first_r_cyc < 0) first_r_cyc = cyc;
            if (vif.OVERRUN && first_ovr_cyc < 0) first_ovr_cyc = cyc;
            if (vif.VIDEO_CLK_SER && !prev_clk_ser) begin
                chk("data_setup", 32'(d), 32'(prev_data));
                if (first_clk_cyc < 0) first_clk_cyc = cyc;
                acc_r = {acc_r[BITS-2:0], d[2]};
                acc_g = {acc_g[BITS-2:0], d[1]};
                acc_b = {acc_b[BITS-2:0], d[0]};
                nbits++;
            end
            if (vif.VIDEO_LAT_SER) begin
                chk("lat_clk_low", 32'(vif.VIDEO_CLK_SER), 32'd0);
                chk("lat_bit_count", 32'(nbits), 32'(BITS));
                pix = {acc_r, acc_g, acc_b};
                if (!loose) begin
                    chk("latch_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) chk("latched_pixel", 32'(pix), 32'(exp_q.pop_front()));
                    chk("no_overrun", 32'(vif.OVERRUN), 32'd0);
                end else begin
                    found = 1'b0;
                    for (int j = last_idx + 1; j < presented.size(); j++) begin
                        if (!found && presented[j] == pix) begin
                            found    = 1'b1;
                            last_idx = j;
                        end
                    end
                    chk("latched_was_presented", 32'(found), 32'd1);
                end
                lat_cyc.push_back(cyc);
                last_pix = pix;
                nbits    = 0;
            end
            if (prev_ovr) chk("overrun_sticky", 32'(vif.OVERRUN), 32'd1);
            prev_clk_ser = vif.VIDEO_CLK_SER;
            prev_ovr     = vif.OVERRUN;
            prev_data    = d;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic present(input logic [BITS-1:0] r, input logic [BITS-1:0] g,
                           input logic [BITS-1:0] b, input int hi, input int lo);
        vif.VIDEO_R = r;
        vif.VIDEO_G = g;
        vif.VIDEO_B = b;
        vif.CLK_6MB = 1'b1;
        if (loose) presented.push_back({r, g, b});
        else       exp_q.push_back({r, g, b});
        tick(hi);
        vif.CLK_6MB = 1'b0;
        tick(lo);
    endtask

    task automatic wait_latches(input int n, input int budget);
        int spent;
        spent = 0;
        while (lat_cyc.size() < n && spent < budget) begin
            tick(1);
            spent++;
        end
        chk("latch_wait_in_budget", 32'(lat_cyc.size() >= n), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : stim
        int k;
        int n;
        vif.CLK_6MB = 1'b0;
        vif.VIDEO_R = '0;
        vif.VIDEO_G = '0;
        vif.VIDEO_B = '0;
        rst = 1'b1;
        tick(4);
        rst = 1'b0;

        // Static CLK_6MB: nothing moves
        idle_check = 1'b1;
        tick(50);
        idle_check = 1'b0;
        chk("idle_no_latch", 32'(lat_cyc.size()), 32'd0);

        // Single pixel with hand-computed timing
        first_r_cyc   = -1;
        first_clk_cyc = -1;
        lat_cyc.delete();
        k = cyc + 1;
        present(7'h55, 7'h2A, 7'h7F, 8, 8);
        wait_latches(1, 60);
        tick(10);
        chk("single_first_msb_cycle", 32'(first_r_cyc), 32'(k + 4));
        chk("single_first_clk_cycle", 32'(first_clk_cyc), 32'(k + 5));
        chk("single_latch_count", 32'(lat_cyc.size()), 32'd1);
        if (lat_cyc.size() > 0) chk("single_latch_cycle", 32'(lat_cyc[0]), 32'(k + 18));
        chk("single_r_bits", 32'(last_pix[3*BITS-1 -: BITS]), 32'h55);
        chk("single_g_bits", 32'(last_pix[2*BITS-1 -: BITS]), 32'h2A);
        chk("single_b_bits", 32'(last_pix[BITS-1 -: BITS]), 32'h7F);

        // Continuous stream at exactly 16:1
        lat_cyc.delete();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            present(v[6:0], ~v[6:0], {v[0], v[7:2]}, 8, 8);
        end
        wait_latches(256, 80);
        chk("cont_latch_count", 32'(lat_cyc.size()), 32'd256);
        for (int i = 1; i < lat_cyc.size(); i++)
            chk("cont_no_gap", 32'(lat_cyc[i] - lat_cyc[i-1]), 32'd16);
        chk("cont_overrun", 32'(vif.OVERRUN), 32'd0);
        chk("cont_drained", 32'(exp_q.size()), 32'd0);

        // Second pixel edge lands in the LOAD cycle of the first
        tick(20);
        lat_cyc.delete();
        vif.VIDEO_R = 7'h12;
        vif.VIDEO_G = 7'h34;
        vif.VIDEO_B = 7'h56;
        vif.CLK_6MB = 1'b1;
        exp_q.push_back({7'h12, 7'h34, 7'h56});
        tick(1);
        vif.CLK_6MB = 1'b0;
        tick(1);
        vif.CLK_6MB = 1'b1;
        tick(1);
        vif.VIDEO_R = 7'h6B;
        vif.VIDEO_G = 7'h0F;
        vif.VIDEO_B = 7'h70;
        exp_q.push_back({7'h6B, 7'h0F, 7'h70});
        tick(4);
        vif.CLK_6MB = 1'b0;
        tick(8);
        wait_latches(2, 60);
        chk("coinc_latch_count", 32'(lat_cyc.size()), 32'd2);
        if (lat_cyc.size() > 1) chk("coinc_spacing", 32'(lat_cyc[1] - lat_cyc[0]), 32'd16);
        chk("coinc_overrun", 32'(vif.OVERRUN), 32'd0);
        chk("coinc_last_pixel", 32'(last_pix), 32'({7'h6B, 7'h0F, 7'h70}));

        // Reset during bit 3
        tick(10);
        lat_cyc.delete();
        vif.VIDEO_R = 7'h3C;
        vif.VIDEO_G = 7'h41;
        vif.VIDEO_B = 7'h1E;
        vif.CLK_6MB = 1'b1;
        exp_q.push_back({7'h3C, 7'h41, 7'h1E});
        tick(8);
        vif.CLK_6MB = 1'b0;
        n = 0;
        while (nbits < 3 && n < 40) begin
            tick(1);
            n++;
        end
        chk("reached_bit3", 32'(nbits), 32'd3);
        rst = 1'b1;
        exp_q.delete();
        tick(3);
        rst = 1'b0;
        tick(5);
        chk("reset_no_latch", 32'(lat_cyc.size()), 32'd0);
        present(7'h01, 7'h40, 7'h33, 8, 8);
        wait_latches(1, 60);
        tick(5);
        chk("after_reset_latch_count", 32'(lat_cyc.size()), 32'd1);
        chk("after_reset_pixel", 32'(last_pix), 32'({7'h01, 7'h40, 7'h33}));

        // Pixels faster than they can be sent (12:1)
        loose = 1'b1;
        presented.delete();
        last_idx      = -1;
        first_ovr_cyc = -1;
        lat_cyc.delete();
        k = cyc + 1;
        for (int i = 0; i < 24; i++) begin
            logic [7:0] v;
            v = 8'(i + 3);
            present(v[6:0], v[6:0] ^ 7'h2B, ~v[6:0], 6, 6);
        end
        tick(50);
        chk("ovr_set", 32'(vif.OVERRUN), 32'd1);
        chk("ovr_first_cycle", 32'(first_ovr_cyc), 32'(k + 50));
        chk("ovr_enough_latches", 32'(lat_cyc.size() >= 16), 32'd1);
        rst = 1'b1;
        tick(2);
        chk("ovr_cleared_by_reset", 32'(vif.OVERRUN), 32'd0);
        rst = 1'b0;
        loose = 1'b0;
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the sequence itself stalls
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
